// File: rtl/decode_pipe.sv
// decode_pipe: instruction queue + decoder + registered control-word output with valid/ready.
// Optional RAW scoreboard enabled by defining DECODE_PIPE_SCOREBOARD_EN.
`default_nettype none

module decode_pipe #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [6:0]       out_opcode,
  output logic [2:0]       out_funct3,
  output logic [6:0]       out_funct7,
  output logic [4:0]       out_rd,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [XLEN-1:0]  out_imm,
  output logic             out_rd_we,
  output logic             out_illegal,
  input  logic             wb_valid,
  input  logic [4:0]       wb_rd,
  output logic [CNT_W-1:0] occupancy
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic [2:0] {
    FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_F, FMT_X
  } fmt_e;

  logic [31:0]      mem_q [DEPTH];
  logic [XLEN-1:0]  pcm_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;

  logic             push, pop, load, hazard, head_valid;
  logic [31:0]      head;
  fmt_e             fmt;
  logic [31:0]      imm32;
  logic             dec_we;

  logic             out_valid_q;
  logic [XLEN-1:0]  out_pc_q, out_imm_q;
  logic [31:0]      out_instr_q;
  logic             out_we_q, out_ill_q;

  assign head_valid = (count_q != '0);
  assign in_ready   = (count_q < CNT_W'(DEPTH));
  assign push       = in_valid && in_ready && !flush;
  assign load       = head_valid && (!out_valid_q || out_ready) && !hazard && !flush;
  assign pop        = load;
  assign head       = mem_q[rd_ptr_q];

  always_comb begin
    fmt = FMT_X;
    case (head[6:0])
      7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011: fmt = FMT_I;
      7'b0100011: fmt = FMT_S;
      7'b1100011: fmt = FMT_B;
      7'b0110111, 7'b0010111: fmt = FMT_U;
      7'b1101111: fmt = FMT_J;
      7'b0110011: fmt = FMT_R;
      7'b0001111: fmt = FMT_F;
      default:    fmt = FMT_X;
    endcase
  end

  // Fence uses the I-format immediate but never writes rd.
  always_comb begin
    imm32 = '0;
    case (fmt)
      FMT_I, FMT_F: imm32 = {{20{head[31]}}, head[31:20]};
      FMT_S: imm32 = {{20{head[31]}}, head[31:25], head[11:7]};
      FMT_B: imm32 = {{19{head[31]}}, head[31], head[7], head[30:25], head[11:8], 1'b0};
      FMT_U: imm32 = {head[31:12], 12'b0};
      FMT_J: imm32 = {{11{head[31]}}, head[31], head[19:12], head[20], head[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  assign dec_we = (fmt == FMT_R || fmt == FMT_I || fmt == FMT_U || fmt == FMT_J) &&
                  (head[11:7] != 5'd0);

`ifdef DECODE_PIPE_SCOREBOARD_EN
  logic [31:0] busy_q, busy_d;
  logic        uses_rs1, uses_rs2;

  assign uses_rs1 = !(fmt == FMT_U || fmt == FMT_J);
  assign uses_rs2 = (fmt == FMT_R || fmt == FMT_S || fmt == FMT_B);
  assign hazard   = (uses_rs1 && busy_q[head[19:15]]) || (uses_rs2 && busy_q[head[24:20]]);

  // Clear is applied before set so a same-index set wins.
  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end else begin
      if (wb_valid) busy_d[wb_rd] = 1'b0;
      if (load && dec_we) busy_d[head[11:7]] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) busy_q <= '0;
    else        busy_q <= busy_d;
  end
`else
  logic unused_wb;
  assign hazard    = 1'b0;
  assign unused_wb = ^{wb_valid, wb_rd};
`endif

  always_comb begin
    count_d = count_q;
    if (flush) count_d = '0;
    else if (push && !pop) count_d = count_q + CNT_W'(1);
    else if (!push && pop) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_instr;
      pcm_q[wr_ptr_q] <= in_pc;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      out_pc_q    <= '0;
      out_imm_q   <= '0;
      out_instr_q <= '0;
      out_we_q    <= 1'b0;
      out_ill_q   <= 1'b0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else if (load) begin
      out_valid_q <= 1'b1;
      out_pc_q    <= pcm_q[rd_ptr_q];
      out_imm_q   <= XLEN'($signed(imm32));
      out_instr_q <= head;
      out_we_q    <= dec_we;
      out_ill_q   <= (fmt == FMT_X);
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_pc      = out_pc_q;
  assign out_opcode  = out_instr_q[6:0];
  assign out_funct3  = out_instr_q[14:12];
  assign out_funct7  = out_instr_q[31:25];
  assign out_rd      = out_instr_q[11:7];
  assign out_rs1     = out_instr_q[19:15];
  assign out_rs2     = out_instr_q[24:20];
  assign out_imm     = out_imm_q;
  assign out_rd_we   = out_we_q;
  assign out_illegal = out_ill_q;
  assign occupancy   = count_q;

endmodule

`default_nettype wire

// File: tb/tb_decode_pipe.sv
// tb_decode_pipe: table-driven decode vectors plus directed fill, flush, reset and hazard sequences.
`default_nettype none

module tb_decode_pipe;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, out_pc, out_imm;
  logic [6:0]  out_opcode, out_funct7;
  logic [2:0]  out_funct3;
  logic [4:0]  out_rd, out_rs1, out_rs2, wb_rd;
  logic        out_rd_we, out_illegal, wb_valid;
  logic [2:0]  occupancy;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic        we, ill;
  } ctl_t;

  typedef struct {
    logic [31:0] instr;
    ctl_t        exp;
  } vec_t;

  vec_t vecs[13];

  decode_pipe dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_opcode(out_opcode), .out_funct3(out_funct3), .out_funct7(out_funct7),
    .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_imm(out_imm),
    .out_rd_we(out_rd_we), .out_illegal(out_illegal),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .occupancy(occupancy)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] instr, input logic [6:0] op, input logic [2:0] f3,
                              input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [31:0] imm, input logic we,
                              input logic ill);
    vec_t v;
    v.instr = instr;
    v.exp   = '{pc: 32'h0, op: op, f3: f3, f7: f7, rd: rd, rs1: rs1, rs2: rs2,
                imm: imm, we: we, ill: ill};
    return v;
  endfunction

  function automatic logic [31:0] addi(input int k);
    return {12'(k), 5'd0, 3'd0, 5'(k), 7'h13};
  endfunction

  task automatic pulse_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  initial begin
    ctl_t act;
    int   acc, idx, seen;
    logic rdy;

    reset = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; flush = 1'b0;
    out_ready = 1'b1; wb_valid = 1'b0; wb_rd = '0;

    vecs[0]  = mk(32'h00500093, 7'h13, 3'd0, 7'h00, 5'd1,  5'd0,  5'd5,  32'h00000005, 1'b1, 1'b0);
    vecs[1]  = mk(32'hFFF00093, 7'h13, 3'd0, 7'h7F, 5'd1,  5'd0,  5'd31, 32'hFFFFFFFF, 1'b1, 1'b0);
    vecs[2]  = mk(32'hFE000EE3, 7'h63, 3'd0, 7'h7F, 5'd29, 5'd0,  5'd0,  32'hFFFFFFFC, 1'b0, 1'b0);
    vecs[3]  = mk(32'h00000000, 7'h00, 3'd0, 7'h00, 5'd0,  5'd0,  5'd0,  32'h00000000, 1'b0, 1'b1);
    vecs[4]  = mk(32'h0000007F, 7'h7F, 3'd0, 7'h00, 5'd0,  5'd0,  5'd0,  32'h00000000, 1'b0, 1'b1);
    vecs[5]  = mk(32'h00528333, 7'h33, 3'd0, 7'h00, 5'd6,  5'd5,  5'd5,  32'h00000000, 1'b1, 1'b0);
    vecs[6]  = mk(32'h0020A423, 7'h23, 3'd2, 7'h00, 5'd8,  5'd1,  5'd2,  32'h00000008, 1'b0, 1'b0);
    vecs[7]  = mk(32'h123451B7, 7'h37, 3'd5, 7'h09, 5'd3,  5'd8,  5'd3,  32'h12345000, 1'b1, 1'b0);
    vecs[8]  = mk(32'h008000EF, 7'h6F, 3'd0, 7'h00, 5'd1,  5'd0,  5'd8,  32'h00000008, 1'b1, 1'b0);
    vecs[9]  = mk(32'h00100013, 7'h13, 3'd0, 7'h00, 5'd0,  5'd0,  5'd1,  32'h00000001, 1'b0, 1'b0);
    vecs[10] = mk(32'h0FF0000F, 7'h0F, 3'd0, 7'h07, 5'd0,  5'd0,  5'd31, 32'h000000FF, 1'b0, 1'b0);
    vecs[11] = mk(32'h00500091, 7'h11, 3'd0, 7'h00, 5'd1,  5'd0,  5'd5,  32'h00000000, 1'b0, 1'b1);
    vecs[12] = mk(32'hFFFFF297, 7'h17, 3'd7, 7'h7F, 5'd5,  5'd31, 5'd31, 32'hFFFFF000, 1'b1, 1'b0);

    // Reset state
    repeat (3) step();
    reset = 1'b1;
    step();
    chk("reset_in_ready", 128'(in_ready), 128'(1'b1));
    chk("reset_out_valid", 128'(out_valid), 128'(1'b0));
    chk("reset_occupancy", 128'(occupancy), 128'(3'd0));
    act = {out_pc, out_opcode, out_funct3, out_funct7, out_rd, out_rs1, out_rs2, out_imm, out_rd_we, out_illegal};
    chk("reset_fields", 128'(act), 128'(0));

    // Table-driven decode vectors, one at a time through an empty pipe
    for (int i = 0; i < 13; i++) begin
      ctl_t exp;
      pulse_flush();
      in_valid = 1'b1;
      in_instr = vecs[i].instr;
      in_pc    = 32'h1000 + 32'(4 * i);
      step();
      in_valid = 1'b0;
      chk($sformatf("latency_v%0d", i), 128'(out_valid), 128'(1'b0));
      step();
      exp    = vecs[i].exp;
      exp.pc = 32'h1000 + 32'(4 * i);
      act = {out_pc, out_opcode, out_funct3, out_funct7, out_rd, out_rs1, out_rs2, out_imm, out_rd_we, out_illegal};
      chk($sformatf("valid_v%0d", i), 128'(out_valid), 128'(1'b1));
      chk($sformatf("decode_v%0d", i), 128'(act), 128'(exp));
      step();
      chk($sformatf("drain_v%0d", i), 128'(out_valid), 128'(1'b0));
    end

    // Fill with out_ready low, then drain in order
    pulse_flush();
    out_ready = 1'b0;
    acc = 0;
    idx = 1;
    for (int c = 0; c < 10; c++) begin
      in_valid = 1'b1;
      in_instr = addi(idx);
      in_pc    = 32'h2000 + 32'(4 * idx);
      rdy      = in_ready;
      step();
      if (rdy) begin
        acc++;
        idx++;
      end
    end
    in_valid = 1'b0;
    chk("fill_accepted", 128'(acc), 128'(5));
    chk("fill_in_ready", 128'(in_ready), 128'(1'b0));
    chk("fill_occupancy", 128'(occupancy), 128'(3'd4));
    chk("fill_hold", 128'({out_valid, out_rd, out_pc}), 128'({1'b1, 5'd1, 32'h2004}));
    out_ready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      chk($sformatf("drain_order_%0d", k), 128'({out_valid, out_rd, out_imm}),
          128'({1'b1, 5'(k), 32'(k)}));
      step();
    end
    chk("drain_empty", 128'({out_valid, in_ready, occupancy}), 128'({1'b0, 1'b1, 3'd0}));

    // Flush with a same-cycle push
    out_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      in_valid = 1'b1;
      in_instr = addi(k + 10);
      step();
    end
    in_valid = 1'b0;
    chk("preflush_state", 128'({out_valid, occupancy}), 128'({1'b1, 3'd3}));
    flush    = 1'b1;
    in_valid = 1'b1;
    in_instr = addi(31);
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_state", 128'({out_valid, occupancy, in_ready}), 128'({1'b0, 3'd0, 1'b1}));
    out_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (out_valid) seen++;
    end
    chk("flush_no_issue", 128'(seen), 128'(0));

    // RAW: LW x5 then ADD x6,x5,x5
    pulse_flush();
    in_valid = 1'b1;
    in_instr = 32'h00002283;
    step();
    in_instr = 32'h00528333;
    step();
    in_valid = 1'b0;
    chk("raw_lw_issue", 128'({out_valid, out_rd, out_rd_we}), 128'({1'b1, 5'd5, 1'b1}));
    step();
`ifdef DECODE_PIPE_SCOREBOARD_EN
    chk("raw_add_held", 128'(out_valid), 128'(1'b0));
    wb_valid = 1'b1;
    wb_rd    = 5'd5;
    step();
    wb_valid = 1'b0;
    chk("raw_add_still_held", 128'(out_valid), 128'(1'b0));
    step();
    chk("raw_add_issue", 128'({out_valid, out_rd, out_rs1, out_rs2}),
        128'({1'b1, 5'd6, 5'd5, 5'd5}));
`else
    chk("raw_add_b2b", 128'({out_valid, out_rd, out_rs1, out_rs2}),
        128'({1'b1, 5'd6, 5'd5, 5'd5}));
`endif
    step();
    chk("raw_drain", 128'(out_valid), 128'(1'b0));

    // Mid-operation reset
    out_ready = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      in_valid = 1'b1;
      in_instr = addi(k);
      step();
    end
    in_valid = 1'b0;
    reset    = 1'b0;
    #2;
    chk("midreset_async", 128'({out_valid, occupancy, out_rd}), 128'({1'b0, 3'd0, 5'd0}));
    step();
    reset     = 1'b1;
    out_ready = 1'b1;
    step();
    step();
    chk("midreset_after", 128'({out_valid, occupancy, in_ready}), 128'({1'b0, 3'd0, 1'b1}));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/decode_pipe.md
Name: decode_pipe

Overview:
- Pipelined, parametrised successor to the single-cycle decode path.
- Buffers fetched instructions in a DEPTH-entry queue and decodes the head entry into a compact control word: fields, register indices, sign-extended immediate, write-enable and illegal flag.
- Presents the control word from an output pipeline register under a valid/ready handshake.
- Sits between fetch and execute. Supports pipeline flush and, optionally, a RAW scoreboard.

Parameters:
- XLEN, 32: data/PC width. Only 32 is supported for now; the immediate is sign-extended to XLEN.
- DEPTH, 4: instruction queue entries. Must be a power of 2 and at least 2.
- CNT_W, $clog2(DEPTH+1): width of the occupancy counter.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  queue can accept an instruction.
- in_instr  in  32  raw instruction.
- in_pc  in  XLEN  PC of in_instr.
- flush  in  1  squash all queued and registered instructions.
- out_valid  out  1  control word valid.
- out_ready  in  1  execute accepts the control word.
- out_pc  out  XLEN  PC of the issued instruction.
- out_opcode  out  7  instr[6:0].
- out_funct3  out  3  instr[14:12].
- out_funct7  out  7  instr[31:25].
- out_rd, out_rs1, out_rs2  out  5 each  register indices.
- out_imm  out  XLEN  sign-extended immediate; 0 for R-type.
- out_rd_we  out  1  writes rd. Forced to 0 when rd==0.
- out_illegal  out  1  unsupported opcode, or instr[1:0] != 2'b11.
- wb_valid  in  1  writeback retire pulse (scoreboard clear).
- wb_rd  in  5  register retired.
- occupancy  out  CNT_W  queue entry count.

Behaviour:
- Reset (asynchronous assert, synchronous release): queue empty, occupancy 0, out_valid 0, all out_* fields 0, scoreboard clear. in_ready is 1 one cycle after release.
- Enqueue: occurs when in_valid && in_ready.
- in_ready = (occupancy < DEPTH). There is no same-cycle pop credit, so a full queue deasserts in_ready even if a pop occurs that cycle.
- Queue storage: circular buffer with wrapping read/write pointers.
- Simultaneous push and pop: occupancy unchanged.
- Decode: combinational from the queue head.
  - Immediate type selected by opcode:
    - I: 0000011, 0010011, 1100111, 1110011
    - S: 0100011
    - B: 1100011
    - U: 0110111, 0010111
    - J: 1101111
    - R (imm=0): 0110011
    - fence 0001111: I format
  - Any other opcode sets out_illegal=1, rd_we=0, imm=0.
  - rd_we=1 for every type except S, B and fence, and only when rd!=0.
- Output register load: loads when the head is valid && (!out_valid || out_ready) && !hazard. This pops the queue.
- If out_valid && out_ready and nothing loads, out_valid drops to 0 the next cycle. Fields hold their last value.
- Latency: an instruction accepted in cycle N appears at the output in cycle N+2 at the earliest. Throughput is 1 per cycle with out_ready held high.
- While out_valid && !out_ready, all out_* fields are held stable.
- Flush takes priority over every other event in the same cycle:
  - Queue emptied, out_valid 0 next cycle.
  - A same-cycle enqueue is discarded.
  - in_ready follows normally next cycle.
- Mid-operation reset: same as reset; in-flight instructions are discarded.

Optional Feature:
- Macro: DECODE_PIPE_SCOREBOARD_EN.
- Defined:
  - A 32-bit busy vector is kept.
  - Set busy[out_rd] on output-register load when rd_we=1.
  - Clear busy[wb_rd] on wb_valid.
  - Set and clear of the same index in the same cycle: set wins.
  - hazard = head uses rs1 (not U/J) and busy[rs1], or head uses rs2 (R/S/B) and busy[rs2]. x0 is never busy.
  - Flush clears the whole vector. Downstream only asserts flush from the writeback stage, after all older instructions have retired.
- Undefined: hazard tied to 0, the vector is absent, and wb_valid/wb_rd are ignored.

Test Plan:
- ADDI x1,x0,5 (0x00500093) pushed with out_ready=1 → two cycles later: out_valid=1, rd=1, rs1=0, imm=0x00000005, rd_we=1, illegal=0.
- ADDI x1,x0,-1 (0xFFF00093) → imm=0xFFFFFFFF. BEQ x0,x0,-4 (0xFE000EE3) → imm=0xFFFFFFFC, rd_we=0.
- DEPTH=4, out_ready=0, continuous in_valid → 5 instructions accepted (4 queued + 1 registered), then in_ready=0 and occupancy=4. Raising out_ready drains them in order with no bubbles.
- Queue holding 3 entries plus out_valid=1, then flush pulsed together with in_valid → next cycle: out_valid=0, occupancy=0, in_ready=1, and the pushed instruction is never issued.
- Instruction 0x00000000 → out_illegal=1, rd_we=0. Opcode 0x7F with low bits 11 → out_illegal=1.
- With DECODE_PIPE_SCOREBOARD_EN: LW x5,0(x0) followed by ADD x6,x5,x5 → the ADD is held, out_valid=0 after the LW is accepted. wb_valid=1, wb_rd=5 → the ADD issues the following cycle. Without the macro, the ADD issues back-to-back with the LW.
